// File: rtl/lsu_mem_port.sv
// Load/store port between the MEM stage and a word-wide data memory.
// Checks the request, steers byte lanes, runs a ready handshake with a
// timeout, and sign/zero-extends load results.
module lsu_mem_port #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [3:0]        mem_byteen,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic              stall_q, stall_d;
  logic              done_d, err_d, rd_d, wr_d;
  logic [3:0]        be_d;
  logic [31:0]       mwd_d, load_d;

  logic              bad_c, misalign_c, illegal_c, accept_c, reject_c;
  logic [3:0]        be_c;
  logic [31:0]       mwd_c, ext_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;

  // Stall covers the accepting cycle combinationally, then the registered ACCESS phase.
  assign stall    = stall_q | accept_c;
  assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};

  // Classify the incoming request as accepted or rejected (only meaningful in IDLE).
  always_comb begin
    misalign_c = 1'b0;
    if (req_write) begin
      illegal_c = funct3[2] | (funct3[1:0] == 2'b11);
    end else begin
      illegal_c = (funct3[1:0] == 2'b11) | (funct3 == 3'b110);
    end
    case (funct3[1:0])
      2'b01:   misalign_c = addr[0];
      2'b10:   misalign_c = (addr[1:0] != 2'b00);
      default: misalign_c = 1'b0;
    endcase
    bad_c    = (req_read & req_write) | illegal_c | misalign_c;
    accept_c = (state_q == S_IDLE) & (req_read | req_write) & ~bad_c;
    reject_c = (state_q == S_IDLE) & (req_read | req_write) & bad_c;
  end

  // Byte enables and replicated store lanes for the incoming request.
  always_comb begin
    be_c  = 4'b1111;
    mwd_c = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_c  = 4'b0001 << addr[1:0];
        mwd_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_c  = 4'b0011 << {addr[1], 1'b0};
        mwd_c = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Pick the addressed byte/halfword from the returned word and extend it.
  always_comb begin
    byte_c = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_c = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ext_c = {{24{byte_c[7]}}, byte_c};
      3'b100:  ext_c = {24'h0, byte_c};
      3'b001:  ext_c = {{16{half_c[15]}}, half_c};
      3'b101:  ext_c = {16'h0, half_c};
      default: ext_c = mem_rdata;
    endcase
  end

  // Next-state and next-output logic; ready beats the timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    stall_d = stall_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rd_d    = mem_read;
    wr_d    = mem_write;
    be_d    = mem_byteen;
    mwd_d   = mem_wdata;
    load_d  = load_data;
    case (state_q)
      S_IDLE: begin
        if (reject_c) begin
          err_d = 1'b1;
        end else if (accept_c) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
          addr_d  = addr;
          f3_d    = funct3;
          stall_d = 1'b1;
          rd_d    = req_read;
          wr_d    = req_write;
          be_d    = be_c;
          mwd_d   = mwd_c;
        end
      end
      S_ACCESS: begin
        if (mem_ready) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          stall_d = 1'b0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (mem_read) begin
            load_d = ext_c;
          end
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          stall_d = 1'b0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        stall_d = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops strobes immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      f3_q       <= '0;
      stall_q    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_byteen <= '0;
      mem_wdata  <= '0;
      load_data  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      f3_q       <= f3_d;
      stall_q    <= stall_d;
      done       <= done_d;
      err        <= err_d;
      mem_read   <= rd_d;
      mem_write  <= wr_d;
      mem_byteen <= be_d;
      mem_wdata  <= mwd_d;
      load_data  <= load_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: directed vector table, random
// transactions against a behavioural model, and a mid-access reset sequence.
module tb_lsu_mem_port;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_read, req_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] load_data;
  logic        stall, done, err;
  logic [31:0] mem_addr;
  logic        mem_read, mem_write;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_mem_port #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_read(req_read), .req_write(req_write), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .load_data(load_data), .stall(stall), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byteen(mem_byteen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // kind: 0 completes, 1 rejected at request, 2 times out
  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdw;
    int          ready_at;
    int          kind;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] load;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", tag, name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rdw, input int ready_at, input int kind,
                              input logic [3:0] be, input logic [31:0] mwd, input logic [31:0] load);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd; v.rdw = rdw;
    v.ready_at = ready_at; v.kind = kind; v.be = be; v.mwd = mwd; v.load = load;
    return v;
  endfunction

  // Behavioural model: derive outcome from access size, offset and direction.
  function automatic void model(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rdw, input int ready_at,
                                input logic [31:0] prev, output int kind, output logic [3:0] be,
                                output logic [31:0] mwd, output logic [31:0] load);
    int size;
    int off;
    bit legal;
    logic [31:0] v;
    logic [31:0] mask;
    off = int'(a[1:0]);
    case (f3[1:0])
      2'b00:   size = 1;
      2'b01:   size = 2;
      2'b10:   size = 4;
      default: size = 0;
    endcase
    legal = (rd != wr) && (size != 0) && !(wr && f3[2]) && (f3 != 3'b110);
    if (legal && (off % size) != 0) legal = 0;
    if (!legal) kind = 1;
    else if (ready_at >= 1 && ready_at <= int'(TIMEOUT)) kind = 0;
    else kind = 2;
    be  = 4'(((1 << size) - 1) << off);
    mwd = '0;
    if (size != 0) begin
      for (int i = 0; i < 4; i++) mwd[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    v = rdw >> (8 * off);
    if (size == 1 || size == 2) begin
      mask = (32'h1 << (8 * size)) - 32'h1;
      v = v & mask;
      if (!f3[2] && v[8*size-1]) v = v | ~mask;
    end
    load = (kind == 0 && rd) ? v : prev;
  endfunction

  // Present one request (entered and left at posedge+1) and check every observable.
  task automatic run_txn(input string tag, input vec_t v, input bit garb);
    int ncyc, acc, rdc, wrc, stallc, donec, errc, evt;
    bit strobe, unstable;
    logic [31:0] ma, mwd;
    logic [3:0] be;
    ncyc = (v.kind == 0) ? v.ready_at + 3 : ((v.kind == 2) ? int'(TIMEOUT) + 3 : 3);
    acc = 0; rdc = 0; wrc = 0; stallc = 0; donec = 0; errc = 0; evt = 0; unstable = 0;
    ma = '0; mwd = '0; be = '0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == 1) begin
        req_read = v.rd; req_write = v.wr; funct3 = v.f3; addr = v.a; wdata = v.wd;
        mem_ready = 1'b0; mem_rdata = $urandom;
      end else begin
        strobe = mem_read | mem_write;
        if (strobe) acc++;
        mem_ready = strobe && (acc == v.ready_at);
        mem_rdata = mem_ready ? v.rdw : $urandom;
        if (garb && (strobe || done)) begin
          req_read = 1'($urandom); req_write = 1'($urandom); funct3 = 3'($urandom);
          addr = $urandom; wdata = $urandom;
        end else begin
          req_read = 1'b0; req_write = 1'b0;
        end
      end
      #1;
      if (mem_read) rdc++;
      if (mem_write) wrc++;
      if (stall) stallc++;
      if (done) begin donec++; if (evt == 0) evt = c; end
      if (err) begin errc++; if (evt == 0) evt = c; end
      if (mem_read || mem_write) begin
        if (rdc + wrc == 1) begin
          ma = mem_addr; be = mem_byteen; mwd = mem_wdata;
        end else if (ma !== mem_addr || be !== mem_byteen || mwd !== mem_wdata) begin
          unstable = 1;
        end
      end
      @(posedge clk); #1;
    end
    req_read = 1'b0; req_write = 1'b0; mem_ready = 1'b0;
    if (v.kind == 0) begin
      chk(tag, "rd_cycles", rdc, v.rd ? v.ready_at : 0);
      chk(tag, "wr_cycles", wrc, v.wr ? v.ready_at : 0);
      chk(tag, "stall_cycles", stallc, v.ready_at + 1);
      chk(tag, "done_cnt", donec, 1);
      chk(tag, "err_cnt", errc, 0);
      chk(tag, "event_cycle", evt, v.ready_at + 2);
    end else if (v.kind == 2) begin
      chk(tag, "rd_cycles", rdc, v.rd ? TIMEOUT : 0);
      chk(tag, "wr_cycles", wrc, v.wr ? TIMEOUT : 0);
      chk(tag, "stall_cycles", stallc, TIMEOUT + 1);
      chk(tag, "done_cnt", donec, 0);
      chk(tag, "err_cnt", errc, 1);
      chk(tag, "event_cycle", evt, TIMEOUT + 2);
    end else begin
      chk(tag, "strobe_cycles", rdc + wrc, 0);
      chk(tag, "stall_cycles", stallc, 0);
      chk(tag, "done_cnt", donec, 0);
      chk(tag, "err_cnt", errc, 1);
      chk(tag, "event_cycle", evt, 2);
    end
    if (v.kind != 1) begin
      chk(tag, "mem_addr", ma, v.a & ~32'h3);
      chk(tag, "byteen", 32'(be), 32'(v.be));
      chk(tag, "stable", 32'(unstable), 0);
      if (v.wr) chk(tag, "mem_wdata", mwd, v.mwd);
    end
    chk(tag, "load_data", load_data, v.load);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_load;
    vec_t        r;
    int          ev;
    int          sel;

    tbl[0]  = mk(1, 0, 3'b000, 32'h103, 32'h0, 32'h80AABBCC, 1, 0, 4'b1000, 32'h0, 32'hFFFFFF80);
    tbl[1]  = mk(1, 0, 3'b101, 32'h102, 32'h0, 32'h80AABBCC, 1, 0, 4'b1100, 32'h0, 32'h000080AA);
    tbl[2]  = mk(1, 0, 3'b001, 32'h100, 32'h0, 32'h80AABBCC, 1, 0, 4'b0011, 32'h0, 32'hFFFFBBCC);
    tbl[3]  = mk(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 1, 0, 4'b1100, 32'hABCDABCD, 32'hFFFFBBCC);
    tbl[4]  = mk(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 1, 1, 4'b0000, 32'h0, 32'hFFFFBBCC);
    tbl[5]  = mk(0, 1, 3'b100, 32'h300, 32'h0, 32'h0, 1, 1, 4'b0000, 32'h0, 32'hFFFFBBCC);
    tbl[6]  = mk(1, 1, 3'b010, 32'h400, 32'h0, 32'h0, 1, 1, 4'b0000, 32'h0, 32'hFFFFBBCC);
    tbl[7]  = mk(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 16, 0, 4'b1111, 32'h0, 32'hDEADBEEF);
    tbl[8]  = mk(1, 0, 3'b010, 32'h104, 32'h0, 32'h11111111, 0, 2, 4'b1111, 32'h0, 32'hDEADBEEF);
    tbl[9]  = mk(0, 1, 3'b000, 32'h003, 32'h00000055, 32'h0, 3, 0, 4'b1000, 32'h55555555, 32'hDEADBEEF);
    tbl[10] = mk(1, 0, 3'b100, 32'h001, 32'h0, 32'h0000F000, 2, 0, 4'b0010, 32'h0, 32'h000000F0);
    tbl[11] = mk(0, 1, 3'b010, 32'h008, 32'hCAFEF00D, 32'h0, 1, 0, 4'b1111, 32'hCAFEF00D, 32'h000000F0);
    tbl[12] = mk(1, 0, 3'b000, 32'h002, 32'h0, 32'h00800000, 2, 0, 4'b0100, 32'h0, 32'hFFFFFF80);
    tbl[13] = mk(1, 0, 3'b101, 32'h003, 32'h0, 32'h0, 1, 1, 4'b0000, 32'h0, 32'hFFFFFF80);

    rst_n = 1'b0;
    req_read = 1'b0; req_write = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    #12;
    chk("reset", "load_data", load_data, 0);
    chk("reset", "strobes", {30'h0, mem_read, mem_write}, 0);
    chk("reset", "stall_done_err", {29'h0, stall, done, err}, 0);
    chk("reset", "mem_addr", mem_addr, 0);
    chk("reset", "byteen", 32'(mem_byteen), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i], i == 12);
    end

    exp_load = tbl[13].load;
    for (int t = 0; t < 50; t++) begin
      sel = int'($urandom % 8);
      r.rd = (sel <= 4); r.wr = (sel == 0) || (sel >= 5);
      sel = int'($urandom % 8);
      case (sel)
        0: r.f3 = 3'b000;
        1: r.f3 = 3'b001;
        2: r.f3 = 3'b010;
        3: r.f3 = 3'b100;
        4: r.f3 = 3'b101;
        default: r.f3 = 3'($urandom);
      endcase
      r.a = $urandom;
      if ($urandom % 2 == 0) r.a[1:0] = 2'b00;
      r.wd = $urandom; r.rdw = $urandom;
      r.ready_at = ($urandom % 4 == 0) ? int'($urandom_range(0, 18)) : int'($urandom_range(1, 3));
      model(r.rd, r.wr, r.f3, r.a, r.wd, r.rdw, r.ready_at, exp_load, r.kind, r.be, r.mwd, r.load);
      run_txn($sformatf("rnd%0d", t), r, 1'($urandom));
      exp_load = r.load;
    end

    // Reset in the middle of an access abandons it silently.
    req_read = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h40; mem_ready = 1'b0;
    @(posedge clk); #1;
    req_read = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid", "strobe_before", 32'(mem_read), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid", "strobes", {30'h0, mem_read, mem_write}, 0);
    chk("rst_mid", "stall_done_err", {29'h0, stall, done, err}, 0);
    chk("rst_mid", "mem_addr", mem_addr, 0);
    chk("rst_mid", "load_data", load_data, 0);
    @(negedge clk); rst_n = 1'b1;
    ev = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done || err || stall || mem_read || mem_write) ev++;
    end
    chk("rst_mid", "quiet_after", ev, 0);
    run_txn("post_rst_sw", mk(0, 1, 3'b010, 32'h300, 32'h600DF00D, 32'h0, 1, 0, 4'b1111, 32'h600DF00D, 32'h0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit between the MEM pipeline stage and a word-wide data memory.
- Consumes the memory-access request produced by instruction decode: read/write strobe plus funct3 size/sign code.
- Performs byte-lane steering, byte-enable generation, misalignment checking, and load sign/zero extension.
- Sequences a ready-handshake memory access, stalls the pipeline until the access completes, and aborts on a timeout.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT, 16, max cycles waiting for MEM_READY before the access is aborted (range 1-255).

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- REQ_READ  input  1  load request from the MEM stage.
- REQ_WRITE  input  1  store request from the MEM stage.
- FUNCT3  input  3  access code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ADDR  input  ADDR_W  byte address (ALU result).
- WDATA  input  32  store data, right-aligned.
- LOAD_DATA  output  32  extended load result (registered).
- STALL  output  1  freezes the pipeline while an access is in flight.
- DONE  output  1  one-cycle pulse when an access completes.
- ERR  output  1  one-cycle pulse on misaligned, illegal, or timed-out access.
- MEM_ADDR  output  ADDR_W  word-aligned address: {ADDR[ADDR_W-1:2], 2'b00}.
- MEM_READ  output  1  memory read strobe.
- MEM_WRITE  output  1  memory write strobe.
- MEM_BYTEEN  output  4  byte lane enables.
- MEM_WDATA  output  32  lane-steered store data.
- MEM_RDATA  input  32  memory read word.
- MEM_READY  input  1  memory completes the access in the cycle it is sampled high.

Behaviour:
- Reset (async, RESET=0):
  - state=IDLE, timeout counter=0.
  - All outputs 0, including LOAD_DATA.
- States: IDLE, ACCESS, DONE.
- IDLE, request check:
  - Error cases (no memory access; ERR pulses the next cycle; stay in IDLE; STALL=0):
    - REQ_READ and REQ_WRITE both high.
    - FUNCT3 illegal: 011, 110 or 111 for a read; anything other than 000/001/010 for a write.
    - Misaligned: H/HU with ADDR[0]=1; W with ADDR[1:0]≠0.
  - Otherwise:
    - Latch ADDR, FUNCT3, WDATA and the direction.
    - STALL=1 combinationally in this same cycle.
    - Next state ACCESS; counter cleared.
- ACCESS:
  - MEM_READ or MEM_WRITE held high; MEM_ADDR, MEM_BYTEEN and MEM_WDATA driven from the latched values and held stable; STALL=1.
  - MEM_READY=1:
    - Strobes drop the next cycle.
    - For a read, LOAD_DATA is captured from MEM_RDATA.
    - Next state DONE.
  - MEM_READY=0: counter increments.
  - Counter reaches TIMEOUT-1 with MEM_READY still 0:
    - Abort: ERR pulse, return to IDLE, LOAD_DATA unchanged.
  - MEM_READY=1 in the same cycle the limit is reached: success; ready wins.
- DONE:
  - DONE=1, STALL=0 for one cycle; next state IDLE.
  - New requests are ignored in DONE; the stage re-presents them in IDLE.
- Byte enables:
  - B: 4'b0001 << ADDR[1:0].
  - H: 4'b0011 << {ADDR[1],1'b0}.
  - W: 4'b1111.
- Store lanes:
  - B: WDATA[7:0] replicated ×4.
  - H: WDATA[15:0] replicated ×2.
  - W: WDATA unchanged.
- Load extraction:
  - Select byte/halfword at offset ADDR[1:0] of MEM_RDATA.
  - B/H: sign-extend. BU/HU: zero-extend. W: pass through.
- LOAD_DATA holds its last value until the next successful load. Stores never change it.
- Minimum access latency: request cycle → ACCESS (≥1 cycle) → DONE, i.e. 3 cycles when memory responds immediately.
- Reset asserted mid-ACCESS:
  - Strobes drop immediately (async); no DONE or ERR is produced.
  - The memory must tolerate an abandoned strobe.
- Request inputs are ignored outside IDLE.

Test Plan:
- LB at ADDR=0x103, MEM_RDATA=0x80AABBCC, MEM_READY=1 on the first ACCESS cycle:
  - MEM_ADDR=0x100, MEM_BYTEEN=1000, LOAD_DATA=0xFFFFFF80.
  - DONE on cycle 3, STALL high for cycles 1-2.
- LHU at ADDR=0x102, same data: LOAD_DATA=0x000080AA. LH at 0x100: LOAD_DATA=0xFFFFBBCC.
- SH at ADDR=0x202, WDATA=0x1234ABCD:
  - MEM_WRITE=1, MEM_ADDR=0x200, MEM_BYTEEN=1100, MEM_WDATA=0xABCDABCD.
  - LOAD_DATA unchanged.
- LW at 0x101; SW with FUNCT3=100; REQ_READ and REQ_WRITE together:
  - Each gives one ERR pulse, MEM_READ/MEM_WRITE never asserted, STALL stays 0.
- With TIMEOUT=16, MEM_READY held 0:
  - ERR after 16 ACCESS cycles, FSM back to IDLE, no DONE.
  - Repeat with MEM_READY=1 on the 16th cycle: DONE, no ERR.
- RESET low during ACCESS: all outputs 0 immediately. After release, a new SW at 0x300 completes normally.
